cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Shares the single physical-memory port between the instruction-cache miss path (feeding the fetch stage) and the data-cache miss/writeback path.
- Sequences one line-sized transaction at a time.
- Latches the granted requester's address and data, and routes pmem_resp/pmem_rdata back only to the granted side.
- Sits between the two caches and the memory interface.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cache line width in bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- i_read  in  1  I-cache line read request.
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line returned to I-cache.
- i_resp  out  1  I-cache transaction complete, one cycle.
- d_read  in  1  D-cache line read request.
- d_write  in  1  D-cache line writeback request.
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  writeback data.
- d_rdata  out  LINE_W  line returned to D-cache.
- d_resp  out  1  D-cache transaction complete, one cycle.
- pmem_read  out  1  memory read command.
- pmem_write  out  1  memory write command.
- pmem_addr  out  ADDR_W  memory address.
- pmem_wdata  out  LINE_W  memory write data.
- pmem_rdata  in  LINE_W  memory read data.
- pmem_resp  in  1  memory done, one cycle.
- arb_busy  out  1  high in any non-IDLE state.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All pmem_* outputs, i_resp, d_resp and arb_busy are 0.
  - Latched addr/wdata are 0.
  - rr_last=I.
  - Takes effect immediately, including mid-transaction. An outstanding memory command is abandoned.
- States: IDLE, I_GNT, D_GNT.
- IDLE:
  - d_read|d_write high, i_read low -> D_GNT.
  - i_read high, d request low -> I_GNT.
  - Both sides requesting -> D_GNT (fixed D priority; see Optional Feature).
  - At the grant edge, latch the granted side's addr into pmem_addr_q. For a D write, also latch d_wdata and op=write.
  - pmem_* are 0 in IDLE.
- I_GNT / D_GNT:
  - pmem_read (or pmem_write) is held high and pmem_addr/pmem_wdata are driven from the latches until pmem_resp=1.
  - Command asserts the cycle after the request is first seen: one cycle of grant latency.
- Completion cycle (pmem_resp=1):
  - Granted side's resp=1 combinationally in the same cycle.
  - Granted side's rdata=pmem_rdata in the same cycle.
  - Next state is IDLE.
- Non-granted side: resp=0 always; rdata is held at its last value.
- Requesters must drop their request in the cycle after resp. A request still high in IDLE is treated as new.
- pmem_resp while in IDLE is ignored, with no resp to either side.
- Requester deasserting mid-grant: the transaction still completes on memory and resp is still pulsed.
- d_read & d_write both high: protocol violation; treated as a write.
- pmem_read and pmem_write are never high together.
- Outputs are derived from state plus registered latches; there is no combinational path from requester inputs to pmem_*.

Optional Feature:
- Macro: CACHE_ARB_RR_EN.
- Defined: round-robin on simultaneous requests. The side not served last wins. rr_last updates on each pmem_resp.
- Undefined: fixed D-over-I priority, and no rr_last register.
- Behaviour is identical when only one side requests.

Decomposition:
- Package arb_pkg:
  - enum arb_state_t {IDLE, I_GNT, D_GNT}.
  - enum arb_src_t {SRC_I, SRC_D}.
  - Localparams LINE_W_DEF=256, ADDR_W_DEF=32.
- Sub-module arb_grant_sel: combinational winner selection from (i_req, d_req, rr_last). Keeps the priority policy swappable and separately testable.

Test Plan:
- I-only read: i_read=1, i_addr=0x0000_0060; memory returns 0xAA.. after 3 cycles -> pmem_read=1 and pmem_addr=0x60 from cycle+1; i_resp=1 and i_rdata=0xAA.. in the pmem_resp cycle; d_resp stays 0.
- Simultaneous requests: i_read and d_read asserted together, d_addr=0x100 -> D served first (pmem_addr=0x100). After d_resp, I is granted with pmem_addr equal to i_addr. With CACHE_ARB_RR_EN and rr_last=D, I is served first instead.
- D writeback: d_write=1, d_addr=0x2000, d_wdata=0x55..55 -> pmem_write=1 with that addr/data held stable until pmem_resp; pmem_read stays 0 throughout.
- Address change mid-grant: i_addr changes from 0x40 to 0x80 while in I_GNT -> pmem_addr stays 0x40 until pmem_resp.
- Stray response: pmem_resp pulsed in IDLE -> i_resp=d_resp=0; state stays IDLE.
- Reset mid-transaction: reset=0 while in D_GNT with pmem_write=1 -> pmem_write=0 asynchronously in the same cycle and state=IDLE. After release, a fresh request is granted normally.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and defaults for the I/D cache memory-port arbiter.
package arb_pkg;

  localparam int unsigned LINE_W_DEF = 256;
  localparam int unsigned ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    I_GNT,
    D_GNT
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner selection between I and D requesters.
// CACHE_ARB_RR_EN selects round-robin on collisions; otherwise D always wins.
module arb_grant_sel
  import arb_pkg::*;
(
  input  logic     i_req_i,
  input  logic     d_req_i,
  input  arb_src_t rr_last_i,
  output logic     gnt_valid_o,
  output arb_src_t gnt_src_o
);

  always_comb begin
    gnt_valid_o = i_req_i | d_req_i;
    gnt_src_o   = SRC_I;
    if (d_req_i && !i_req_i) begin
      gnt_src_o = SRC_D;
    end else if (d_req_i && i_req_i) begin
`ifdef CACHE_ARB_RR_EN
      // The side not served most recently wins a collision.
      gnt_src_o = (rr_last_i == SRC_D) ? SRC_I : SRC_D;
`else
      gnt_src_o = SRC_D;
`endif
    end
  end

`ifndef CACHE_ARB_RR_EN
  logic unused_rr;
  assign unused_rr = rr_last_i;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache miss paths.
// Define CACHE_ARB_RR_EN for round-robin collision handling (default: D priority).
module cache_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              arb_busy
);

  arb_state_t        state_q, state_d;
  logic              op_write_q, op_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  arb_src_t          rr_last;
  logic              gnt_valid;
  arb_src_t          gnt_src;
  logic              d_req;

  assign d_req = d_read | d_write;

  arb_grant_sel u_grant_sel (
    .i_req_i     (i_read),
    .d_req_i     (d_req),
    .rr_last_i   (rr_last),
    .gnt_valid_o (gnt_valid),
    .gnt_src_o   (gnt_src)
  );

`ifdef CACHE_ARB_RR_EN
  arb_src_t rr_last_q, rr_last_d;

  always_comb begin
    rr_last_d = rr_last_q;
    if (pmem_resp && (state_q == I_GNT)) rr_last_d = SRC_I;
    if (pmem_resp && (state_q == D_GNT)) rr_last_d = SRC_D;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_last_q <= SRC_I;
    else        rr_last_q <= rr_last_d;
  end

  assign rr_last = rr_last_q;
`else
  assign rr_last = SRC_I;
`endif

  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid && (gnt_src == SRC_D)) begin
          state_d    = D_GNT;
          addr_d     = d_addr;
          // A simultaneous read+write is a protocol violation; the write wins.
          op_write_d = d_write;
          wdata_d    = d_write ? d_wdata : '0;
        end else if (gnt_valid) begin
          state_d    = I_GNT;
          addr_d     = i_addr;
          op_write_d = 1'b0;
          wdata_d    = '0;
        end
      end
      I_GNT: begin
        if (pmem_resp) begin
          state_d   = IDLE;
          i_rdata_d = pmem_rdata;
        end
      end
      D_GNT: begin
        if (pmem_resp) begin
          state_d   = IDLE;
          d_rdata_d = pmem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Memory-side outputs depend only on registered state, never on requester inputs.
  always_comb begin
    arb_busy   = (state_q != IDLE);
    pmem_read  = arb_busy & ~op_write_q;
    pmem_write = arb_busy & op_write_q;
    pmem_addr  = arb_busy ? addr_q : '0;
    pmem_wdata = arb_busy ? wdata_q : '0;
    i_resp     = (state_q == I_GNT) & pmem_resp;
    d_resp     = (state_q == D_GNT) & pmem_resp;
    i_rdata    = i_resp ? pmem_rdata : i_rdata_q;
    d_rdata    = d_resp ? pmem_rdata : d_rdata_q;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized and directed bench for cache_arbiter against a transaction-level model.
module tb_cache_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, pmem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic [AW-1:0] pmem_addr;
  logic          i_resp, d_resp, pmem_read, pmem_write, arb_busy;

  int checks = 0;
  int errors = 0;

  // Model state: which side was served last (0 = I, 1 = D) and last line returned per side.
  int            m_rr_last = 0;
  logic [LW-1:0] m_i_last, m_d_last;
  bit            m_i_seen = 0;
  bit            m_d_seen = 0;

  cache_arbiter #(
    .ADDR_W (AW),
    .LINE_W (LW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp),
    .arb_busy   (arb_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = $urandom;
    return a & ~32'h1F;
  endfunction

  // 0 = I wins, 1 = D wins.
  function automatic int pick(input bit ir, input bit dreq);
    if (ir && dreq) begin
`ifdef CACHE_ARB_RR_EN
      return (m_rr_last == 1) ? 0 : 1;
`else
      return 1;
`endif
    end
    return dreq ? 1 : 0;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, arb_busy, 1'b0);
    chk({tag, "_rd"}, pmem_read, 1'b0);
    chk({tag, "_wr"}, pmem_write, 1'b0);
    chk({tag, "_addr"}, pmem_addr, '0);
  endtask

  // Entered just after a rising edge with the arbiter idle; leaves it idle again.
  task automatic txn(input bit ir, input bit dr, input bit dw, input logic [AW-1:0] ia,
                     input logic [AW-1:0] da, input logic [LW-1:0] wd, input int lat,
                     input logic [LW-1:0] rd, input bit wiggle);
    int            win;
    bit            is_wr;
    logic [AW-1:0] exp_addr;
    i_read  = ir;
    d_read  = dr;
    d_write = dw;
    i_addr  = ia;
    d_addr  = da;
    d_wdata = wd;
    win      = pick(ir, dr | dw);
    is_wr    = (win == 1) && dw;
    exp_addr = (win == 1) ? da : ia;
    #1;
    check_idle("req_cycle");
    @(posedge clk); #1;
    for (int k = 0; k < lat; k++) begin
      chk("gnt_busy", arb_busy, 1'b1);
      chk("gnt_rd", pmem_read, !is_wr);
      chk("gnt_wr", pmem_write, is_wr);
      chk("gnt_addr", pmem_addr, exp_addr);
      if (is_wr) chk("gnt_wdata", pmem_wdata, wd);
      chk("gnt_iresp", i_resp, 1'b0);
      chk("gnt_dresp", d_resp, 1'b0);
      if (wiggle) begin
        i_addr  = rand_addr();
        d_addr  = rand_addr();
        d_wdata = rand_line();
        if ($urandom_range(2) == 0) begin
          if (win == 1) begin d_read = 0; d_write = 0; end
          else i_read = 0;
        end
      end
      @(posedge clk); #1;
    end
    pmem_resp  = 1'b1;
    pmem_rdata = rd;
    #1;
    chk("cpl_rd", pmem_read, !is_wr);
    chk("cpl_wr", pmem_write, is_wr);
    chk("cpl_addr", pmem_addr, exp_addr);
    if (win == 0) begin
      chk("cpl_iresp", i_resp, 1'b1);
      chk("cpl_dresp", d_resp, 1'b0);
      chk("cpl_irdata", i_rdata, rd);
      if (m_d_seen) chk("hold_drdata", d_rdata, m_d_last);
      m_i_last = rd;
      m_i_seen = 1;
    end else begin
      chk("cpl_dresp", d_resp, 1'b1);
      chk("cpl_iresp", i_resp, 1'b0);
      chk("cpl_drdata", d_rdata, rd);
      if (m_i_seen) chk("hold_irdata", i_rdata, m_i_last);
      m_d_last = rd;
      m_d_seen = 1;
    end
    m_rr_last = win;
    @(posedge clk); #1;
    pmem_resp  = 1'b0;
    pmem_rdata = rand_line();
    if (win == 1) begin d_read = 0; d_write = 0; end
    else i_read = 0;
    check_idle("post_cpl");
    chk("post_iresp", i_resp, 1'b0);
    chk("post_dresp", d_resp, 1'b0);
    if (win == 0) chk("post_irdata", i_rdata, rd);
    else chk("post_drdata", d_rdata, rd);
  endtask

  initial begin
    logic [LW-1:0] line;
    bit ir, dr, dw;
    reset = 1'b1;
    {i_read, d_read, d_write, pmem_resp} = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
    #2 reset = 1'b0;
    #1;
    check_idle("reset");
    chk("reset_iresp", i_resp, 1'b0);
    chk("reset_dresp", d_resp, 1'b0);
    chk("reset_wdata", pmem_wdata, '0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // I-only read
    line = {32{8'hAA}};
    txn(1, 0, 0, 32'h60, 32'h0, '0, 3, line, 0);
    // Simultaneous requests, then the remaining side
    txn(1, 1, 0, 32'h1C0, 32'h100, '0, 2, rand_line(), 0);
    txn(i_read, 0, 0, 32'h1C0, 32'h0, '0, 1, rand_line(), 0);
    // Collision right after a D-only transaction
    txn(0, 1, 0, 32'h0, 32'h300, '0, 0, rand_line(), 0);
    txn(1, 1, 0, 32'h440, 32'h500, '0, 2, rand_line(), 0);
    // D writeback
    line = {64{4'h5}};
    txn(0, 0, 1, 32'h0, 32'h2000, line, 3, rand_line(), 0);
    // Address changes while granted
    txn(1, 0, 0, 32'h40, 32'h0, '0, 4, rand_line(), 1);
    {i_read, d_read, d_write} = '0;

    // Stray response while idle
    pmem_resp  = 1'b1;
    pmem_rdata = rand_line();
    #1;
    chk("stray_iresp", i_resp, 1'b0);
    chk("stray_dresp", d_resp, 1'b0);
    chk("stray_irdata", i_rdata, m_i_last);
    chk("stray_drdata", d_rdata, m_d_last);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    check_idle("stray_after");

    // Reset mid-transaction
    d_write = 1'b1; d_addr = 32'h3000; d_wdata = rand_line();
    @(posedge clk); #1;
    chk("rst_mid_pre_wr", pmem_write, 1'b1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("rst_mid_wr", pmem_write, 1'b0);
    check_idle("rst_mid");
    d_write = 1'b0;
    m_rr_last = 0;
    m_i_seen = 0;
    m_d_seen = 0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check_idle("rst_rel");
    txn(0, 1, 0, 32'h0, 32'h3400, '0, 1, rand_line(), 0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      ir = ($urandom_range(2) != 0);
      dr = ($urandom_range(2) == 0);
      dw = ($urandom_range(3) == 0);
      if (!(ir || dr || dw)) begin
        {i_read, d_read, d_write} = '0;
        pmem_resp  = $urandom_range(1);
        pmem_rdata = rand_line();
        #1;
        chk("rnd_idle_iresp", i_resp, 1'b0);
        chk("rnd_idle_dresp", d_resp, 1'b0);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        check_idle("rnd_idle");
      end else begin
        txn(ir, dr, dw, rand_addr(), rand_addr(), rand_line(), $urandom_range(4),
            rand_line(), $urandom_range(1) == 1);
      end
    end
    {i_read, d_read, d_write} = '0;
    @(posedge clk); #1;
    check_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
